stream_packer: RTL and testbench
================================

// Module: stream_packer
// PURPOSE
//  Lossless successor to the trace-path data packer. Packs input vectors of per-chain
//  length (N, M, 1 or drop) into N-lane output vectors with exact lane splitting, so a
//  partial vector is carried into the next output and never lost. It adds valid/ready
//  backpressure and an eof flush. It sits between the filter/reduce stages and the trace buffer.
// PARAMETERS
//  N                  8   lanes per input and output vector; N>=2
//  M                  2   medium packing length; 1<M<N
//  DATA_WIDTH         32  bits per lane
//  MAX_CHAINS         4   number of firmware chains; CW=$clog2(MAX_CHAINS), min 1
//  PERSONAL_CONFIG_ID 0   configId value that addresses this block
// PORTS
//  clk         in   1            clock, rising edge
//  reset_n     in   1            asynchronous, active-low reset
//  tracing     in   1            global enable; input beats are accepted only while high
//  valid_in    in   1            input beat valid
//  ready_in    out  1            block can accept a beat this cycle
//  eof_in      in   1            last beat of frame; qualified by the input handshake
//  chainId_in  in   CW           selects the firmware entry for this beat
//  configId    in   8            configuration bus target ID
//  configData  in   8            configuration bus payload
//  vector_in   in   N*DW         lanes [N-1:0]; lane 0 is the first element
//  vector_out  out  N*DW         packed output; lane 0 is the oldest element
//  valid_out   out  1            output valid
//  ready_out   in   1            downstream accepts the output
//  lanes_out   out  $clog2(N+1)  number of meaningful lanes in vector_out (1..N)
// BEHAVIOUR
//  - Reset (async): valid_out=0, vector_out=0, lanes_out=0, fill=0, buffer=0,
//    all firmware=0, config pointer=0, state=RUN. Reset mid-frame discards the held residue.
//  - Firmware code to length L: 0->N, 1->M, 2->1; codes 3..255 mean drop.
//    A dropped beat is still handshaken but appends nothing. If eof_in is set on it, eof still applies.
//  - Input handshake: accept = valid_in & ready_in & tracing.
//    ready_in = (state==RUN) & (!valid_out | ready_out).
//    When tracing=0 nothing is accepted, but a held output still drains.
//  - Buffer: 2N lanes, fill count 0..N-1 between beats. An accepted beat writes
//    vector_in[L-1:0] at lanes fill..fill+L-1. Let t=fill+L.
//  - t<N without eof: fill<=t; no output.
//  - t>=N: vector_out<=lanes[N-1:0], lanes_out<=N, valid_out<=1; remaining lanes shift
//    down to 0 and fill<=t-N. At most one full output per beat, since t<2N.
//  - eof with 0<t<N: emit lanes[t-1:0] zero-padded, lanes_out=t, fill<=0.
//  - eof with t>N: emit the full vector, state<=FLUSH. In FLUSH, on the next output slot
//    emit the residue (t-N lanes, zero-padded), fill<=0, state<=RUN.
//  - eof with t==N: emit once, fill<=0. eof with t==0: no output.
//  - Output register: vector_out and lanes_out stay stable while valid_out & !ready_out.
//    valid_out drops the cycle after the handshake unless a new vector is loaded in the same cycle.
//  - Latency: one cycle from the completing input beat to valid_out.
//  - Throughput: one beat per cycle when ready_out is held at 1.
//  - FSM RUN->FLUSH only on eof with t>N. FLUSH->RUN when the residue is loaded.
//    FLUSH lasts at most one cycle under ready_out=1.
// CONFIGURATION
//  - Each cycle with configId==PERSONAL_CONFIG_ID: firmware[ptr]<=configData and
//    ptr<=ptr+1, wrapping at MAX_CHAINS.
//  - Any other configId resets ptr to 0.
//  - A config write and a data beat in the same cycle: the beat uses the firmware value
//    from before the write.
//  - STREAM_PACKER_STATS_EN defined: adds output vectors_emitted[31:0]. It resets to 0,
//    increments on each valid_out&ready_out, and saturates at 2^32-1.
//  - STREAM_PACKER_STATS_EN undefined: the port and counter are absent.
// TESTING
//  1. All chains code 0, vectors 1..8, 9..16 back-to-back with ready_out=1
//     -> two outputs, one cycle after each input, lanes_out=8.
//  2. Code 2; send 1,2,...,8 in lanes 0
//     -> one output {8..1} (lane0=1) after the 8th beat; no earlier valid_out.
//  3. Code 1, N=8 M=2; three beats {1,2},{3,4},{5,6} then {7,8} with eof
//     -> single output 1..8, lanes_out=8, fill=0.
//  4. fill=6, code 0 beat 11..18 with eof
//     -> output {x,x,x,x,x,x,11,12}, then next cycle {13..18,0,0} with lanes_out=6;
//        ready_in=0 during FLUSH.
//  5. Hold ready_out=0 for 5 cycles with an output pending
//     -> vector_out stable, ready_in=0, no beat lost; release -> resume in order.
//  6. Assert reset_n low mid-frame with fill=3 and valid_out=1
//     -> valid_out=0 immediately (asynchronous); after release a 1-lane beat with eof
//        emits lanes_out=1.

Source files
------------

// File: rtl/stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stream_packer                                                   |
// | Purpose  : Lossless lane packer for the trace path. Each accepted beat      |
// |            contributes N, M, 1 or 0 lanes (chosen per chain by a firmware   |
// |            code). Lanes are appended to a residue buffer, and full N-lane   |
// |            vectors are emitted. eof flushes the partial residue.            |
// |            valid/ready handshakes are provided on both sides.               |
// | Ports    : clk, reset_n (async, active-low)                                |
// |            tracing             - global enable for accepting input beats    |
// |            valid_in/ready_in   - input handshake                            |
// |            eof_in, chainId_in  - frame end and firmware entry select        |
// |            configId/configData - firmware configuration bus                 |
// |            vector_in           - N lanes, lane 0 first                      |
// |            vector_out/valid_out/ready_out/lanes_out - packed output         |
// |            vectors_emitted     - output handshake count (STATS build only)  |
// | Options  : `define STREAM_PACKER_STATS_EN adds the vectors_emitted counter  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module stream_packer #(
  parameter int N                  = 8,
  parameter int M                  = 2,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int LW = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tracing,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    eof_in,
  input  logic [CW-1:0]           chainId_in,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic                    valid_out,
  input  logic                    ready_out,
`ifdef STREAM_PACKER_STATS_EN
  output logic [LW-1:0]           lanes_out,
  output logic [31:0]             vectors_emitted
`else
  output logic [LW-1:0]           lanes_out
`endif
);

  localparam int TW = $clog2(2 * N);
  localparam int VW = N * DATA_WIDTH;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]    state;
  logic [LW-1:0] fill;
  // Residue lanes at and above fill are always zero, so the residue can be
  // OR-merged with the incoming lanes and emitted without extra masking.
  logic [VW-1:0] residue;

  // Sized to the full index range; entries past MAX_CHAINS are never written
  // and decode as code 0.
  logic [7:0]    firmware [2**CW];
  logic [CW-1:0] cfg_ptr;

  logic [7:0]    code;
  logic [LW-1:0] len;
  logic [TW-1:0] total;
  logic [VW-1:0] vin_masked;
  logic [2*VW-1:0] merged;
  logic          out_free;
  logic          accept;

  assign out_free = !valid_out || ready_out;
  assign ready_in = (state == ST_RUN) && out_free;
  assign accept   = valid_in && ready_in && tracing;

  assign code  = firmware[chainId_in];
  assign total = TW'(fill) + TW'(len);

  always_comb begin
    len = '0;
    case (code)
      8'd0:    len = LW'(N);
      8'd1:    len = LW'(M);
      8'd2:    len = LW'(1);
      default: len = '0;
    endcase
  end

  // Keep only the first len lanes of the beat, then place them above the residue.
  always_comb begin
    vin_masked = '0;
    for (int j = 0; j < N; j++) begin
      if (j < int'(len)) begin
        vin_masked[j*DATA_WIDTH +: DATA_WIDTH] = vector_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    merged = {{VW{1'b0}}, residue} | ({{VW{1'b0}}, vin_masked} << (int'(fill) * DATA_WIDTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      fill       <= '0;
      residue    <= '0;
      vector_out <= '0;
      lanes_out  <= '0;
      valid_out  <= 1'b0;
    end else begin
      if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
      if (state == ST_FLUSH) begin
        // Residue left over from an eof beat that overflowed one vector.
        if (out_free) begin
          vector_out <= residue;
          lanes_out  <= fill;
          valid_out  <= 1'b1;
          residue    <= '0;
          fill       <= '0;
          state      <= ST_RUN;
        end
      end else if (accept) begin
        if (total >= TW'(N)) begin
          vector_out <= merged[VW-1:0];
          lanes_out  <= LW'(N);
          valid_out  <= 1'b1;
          // Upper half is empty when total==N, so this also clears on exact fit.
          residue    <= merged[2*VW-1:VW];
          fill       <= LW'(total - TW'(N));
          if (eof_in && (total > TW'(N))) begin
            state <= ST_FLUSH;
          end
        end else if (eof_in) begin
          if (total != '0) begin
            vector_out <= merged[VW-1:0];
            lanes_out  <= LW'(total);
            valid_out  <= 1'b1;
          end
          residue <= '0;
          fill    <= '0;
        end else begin
          residue <= merged[VW-1:0];
          fill    <= LW'(total);
        end
      end
    end
  end

  // Config writes land at the clock edge, so a beat in the same cycle still
  // decodes with the previous firmware value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_ptr <= '0;
      for (int i = 0; i < 2**CW; i++) begin
        firmware[i] <= 8'd0;
      end
    end else if (configId == 8'(PERSONAL_CONFIG_ID)) begin
      firmware[cfg_ptr] <= configData;
      cfg_ptr           <= (cfg_ptr == CW'(MAX_CHAINS - 1)) ? '0 : cfg_ptr + 1'b1;
    end else begin
      cfg_ptr <= '0;
    end
  end

`ifdef STREAM_PACKER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vectors_emitted <= '0;
    end else if (valid_out && ready_out && (vectors_emitted != 32'hFFFF_FFFF)) begin
      vectors_emitted <= vectors_emitted + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
module tb_stream_packer;
  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int LW = $clog2(N + 1);

  typedef struct {
    int              lanes;
    logic [N*DW-1:0] vec;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            tracing = 1'b0;
  logic            valid_in = 1'b0;
  logic            ready_in;
  logic            eof_in = 1'b0;
  logic [1:0]      chainId_in = '0;
  logic [7:0]      configId = 8'hFF;
  logic [7:0]      configData = 8'h00;
  logic [N*DW-1:0] vector_in = '0;
  logic [N*DW-1:0] vector_out;
  logic            valid_out;
  logic            ready_out = 1'b0;
  logic [LW-1:0]   lanes_out;

  stream_packer #(.N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(0)) dut (
    .clk(clk), .reset_n(reset_n), .tracing(tracing), .valid_in(valid_in), .ready_in(ready_in),
    .eof_in(eof_in), .chainId_in(chainId_in), .configId(configId), .configData(configData),
    .vector_in(vector_in), .vector_out(vector_out), .valid_out(valid_out), .ready_out(ready_out),
    .lanes_out(lanes_out)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          tb_fw [4] = '{0, 0, 0, 0};
  logic [31:0] mq [$];
  exp_t        exp_q [$];
  bit          rnd = 0;

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int code2len(input int c);
    if (c == 0) return N;
    if (c == 1) return M;
    if (c == 2) return 1;
    return 0;
  endfunction

  function automatic logic [N*DW-1:0] mkvec(input int base);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 32'(base + i);
    return v;
  endfunction

  // Reference: a flat element stream cut into N-element chunks; eof flushes the tail.
  task automatic emit(input int k);
    exp_t e;
    e.vec   = '0;
    e.lanes = k;
    for (int i = 0; i < k; i++) e.vec[i*DW +: DW] = mq.pop_front();
    exp_q.push_back(e);
  endtask

  task automatic model_beat(input int ch, input logic [N*DW-1:0] v, input bit eof);
    int l;
    l = code2len(tb_fw[ch]);
    for (int j = 0; j < l; j++) mq.push_back(v[j*DW +: DW]);
    if (mq.size() >= N) emit(N);
    if (eof && mq.size() > 0) emit(mq.size());
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int ch, input logic [N*DW-1:0] v, input bit eof);
    int waits;
    bit ok;
    waits = 0;
    ok = 0;
    chainId_in = 2'(ch);
    vector_in  = v;
    eof_in     = eof;
    valid_in   = 1'b1;
    while (!ok && waits < 200) begin
      @(negedge clk);
      if (ready_in === 1'b1 && tracing === 1'b1) ok = 1;
      else begin
        waits++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles, required acceptance", waits);
    end else begin
      model_beat(ch, v, eof);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    eof_in   = 1'b0;
  endtask

  task automatic cfg(input int c0, input int c1, input int c2, input int c3);
    int c [4];
    c = '{c0, c1, c2, c3};
    configId = 8'hFF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      configId   = 8'h00;
      configData = 8'(c[i]);
      @(posedge clk);
      #1;
      tb_fw[i] = c[i];
    end
    configId = 8'hFF;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d outputs still pending, required 0", name, exp_q.size());
    end
  endtask

  function automatic int rand_code();
    int r;
    r = int'($urandom_range(0, 4));
    if (r >= 3) return int'($urandom_range(3, 255));
    return r;
  endfunction

  initial begin
    logic [N*DW-1:0] held;

    // Scoreboard monitor: every output handshake pops one expected vector.
    fork
      forever begin
        @(negedge clk);
        if (reset_n === 1'b1 && valid_out === 1'b1 && ready_out === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got lanes_out=%0d vector=%h, required no output", lanes_out, vector_out);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_lanes", N*DW'(lanes_out), N*DW'(e.lanes));
            chk("sb_vector", vector_out, e.vec);
          end
        end
      end
      forever begin
        @(posedge clk);
        #1;
        if (rnd) begin
          ready_out = ($urandom_range(0, 3) != 0);
          tracing   = ($urandom_range(0, 9) != 0);
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_valid", N*DW'(valid_out), '0);
    chk("rst_lanes", N*DW'(lanes_out), '0);
    chk("rst_vector", vector_out, '0);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    tracing   = 1'b1;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_in", N*DW'(ready_in), N*DW'(1));

    // 1: full-length beats, one output per beat one cycle later
    cfg(0, 1, 2, 0);
    send(0, mkvec(1), 0);
    chk("t1_latency_a", N*DW'(valid_out), N*DW'(1));
    send(3, mkvec(9), 0);
    chk("t1_latency_b", N*DW'(valid_out), N*DW'(1));
    wait_drain("t1_drain");

    // 2: single-lane beats, one output only after the eighth
    for (int k = 1; k <= 8; k++) begin
      send(2, mkvec(k), 0);
      if (k < 8) chk("t2_no_early_valid", N*DW'(valid_out), '0);
      else chk("t2_valid_after_8", N*DW'(valid_out), N*DW'(1));
    end
    wait_drain("t2_drain");

    // 3: medium-length beats closing exactly at N with eof
    send(1, mkvec(1), 0);
    send(1, mkvec(3), 0);
    send(1, mkvec(5), 0);
    send(1, mkvec(7), 1);
    chk("t3_valid", N*DW'(valid_out), N*DW'(1));
    wait_drain("t3_drain");

    // 4: fill=6 then a full beat with eof -> full vector then 6-lane residue
    send(1, mkvec(1), 0);
    send(1, mkvec(3), 0);
    send(1, mkvec(5), 0);
    send(0, mkvec(11), 1);
    chk("t4_ready_in_flush", N*DW'(ready_in), '0);
    wait_drain("t4_drain");

    // 5: backpressure holds the output stable and blocks input
    ready_out = 1'b0;
    send(0, mkvec(40), 0);
    held = vector_out;
    fork
      send(0, mkvec(60), 0);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("t5_stable", vector_out, held);
          chk("t5_ready_in_low", N*DW'(ready_in), '0);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    wait_drain("t5_drain");

    // Randomized traffic with random backpressure, gaps and firmware
    rnd = 1;
    for (int b = 0; b < 300; b++) begin
      logic [N*DW-1:0] v;
      if (b % 60 == 0) cfg(rand_code(), rand_code(), rand_code(), rand_code());
      for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
      send(int'($urandom_range(0, 3)), v, (b == 299) || ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd = 0;
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    tracing   = 1'b1;
    wait_drain("rand_drain");

    // 6: async reset mid-frame with residue and a held output
    cfg(0, 1, 2, 0);
    send(1, mkvec(100), 0);
    send(2, mkvec(200), 0);
    ready_out = 1'b0;
    send(0, mkvec(300), 0);
    chk("t6_pending", N*DW'(valid_out), N*DW'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", N*DW'(valid_out), '0);
    chk("t6_async_lanes", N*DW'(lanes_out), '0);
    exp_q.delete();
    mq.delete();
    tb_fw = '{0, 0, 0, 0};
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    ready_out = 1'b1;
    cfg(2, 2, 2, 2);
    send(0, mkvec(500), 1);
    chk("t6_valid", N*DW'(valid_out), N*DW'(1));
    chk("t6_lanes", N*DW'(lanes_out), N*DW'(1));
    wait_drain("t6_drain");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
